// File: rtl/reg_file_if.sv
// Register-file access bundle: one write port, two read ports, write acknowledge.
interface reg_file_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [W-1:0]  rd_data_a;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  rd_data_b;
  logic          wr_ack;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_ack
  );
endinterface

// File: rtl/reg_file.sv
// Flop-based DEPTH x W register file: one synchronous write port, two combinational
// read ports, optional write-to-read bypass and hardwired-zero word 0.
module reg_file #(
  parameter int unsigned   W         = 32,
  parameter int unsigned   AW        = 5,
  parameter logic [W-1:0]  RESET_VAL = '0,
  parameter bit            ZERO_REG  = 1'b1,
  parameter bit            BYPASS    = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  reg_file_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  logic         wr_ack;
  logic         wr_keep;
  logic         fwd;
  logic [W-1:0] rd_a;
  logic [W-1:0] rd_b;

  // Writes to the zero register are acknowledged but never stored.
  assign wr_keep = !(ZERO_REG && (bus.wr_addr == '0));
  assign fwd     = bus.wr_en & ~clr & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '{default: RESET_VAL};
      wr_ack <= 1'b0;
    end else if (clr) begin
      mem    <= '{default: RESET_VAL};
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= bus.wr_en;
      if (bus.wr_en && wr_keep)
        mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rd_a = mem[bus.rd_addr_a];
    if (BYPASS && fwd && (bus.rd_addr_a == bus.wr_addr))
      rd_a = bus.wr_data;
    if (ZERO_REG && (bus.rd_addr_a == '0))
      rd_a = '0;
  end

  always_comb begin
    rd_b = mem[bus.rd_addr_b];
    if (BYPASS && fwd && (bus.rd_addr_b == bus.wr_addr))
      rd_b = bus.wr_data;
    if (ZERO_REG && (bus.rd_addr_b == '0))
      rd_b = '0;
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.wr_ack    = wr_ack;
endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-port register file for the ALU datapath: DEPTH words of W bits, one synchronous write port and two asynchronous read ports. Every word has an asynchronous active-high reset and a synchronous bulk clear. Optional write-to-read bypass and a hardwired-zero register 0 are available. It is the generalised successor of the plain W-bit clocked register and feeds the ALU A/B operands directly.

## Interface

**Parameters**
- W, 32, word width in bits; legal range 1..64
- AW, 5, address width; DEPTH = 2**AW words
- RESET_VAL, 0, W-bit value loaded into every word on rst or clr
- ZERO_REG, 1, when 1, word 0 always reads 0 and ignores writes
- BYPASS, 1, when 1, a read of the address being written returns wr_data in the same cycle

**Ports**
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of all words to RESET_VAL
- wr_en  input  1  write enable
- wr_addr  input  AW  write address
- wr_data  input  W  write data
- rd_addr_a  input  AW  read port A address
- rd_data_a  output  W  read port A data, combinational
- rd_addr_b  input  AW  read port B address
- rd_data_b  output  W  read port B data, combinational
- wr_ack  output  1  registered; high for one cycle after an accepted write

## Operation

- Storage is DEPTH x W flops; no memory macro is used.
- Write: at a rising clk edge with wr_en=1 and clr=0, word[wr_addr] <= wr_data.
- Writes to address 0 are discarded when ZERO_REG=1. wr_ack is still asserted for them.
- clr=1 at an edge sets every word to RESET_VAL.
- clr has priority over wr_en; a write in the same cycle as clr is lost and wr_ack=0.
- rst=1 immediately, without clk:
  - sets every word to RESET_VAL
  - drives wr_ack to 0
- rst dominates clr and wr_en.
- Read ports are independent and may address the same word.
- rd_data_x = word[rd_addr_x], except:
  - ZERO_REG=1 and rd_addr_x=0 gives 0. This holds even when RESET_VAL != 0.
  - BYPASS=1, wr_en=1, clr=0, rst=0 and rd_addr_x=wr_addr (and not the zero register) gives wr_data.
- BYPASS=0: same-address read during a write returns the old value until after the edge.
- wr_ack <= wr_en & ~clr, registered.
- No out-of-range addresses exist, since DEPTH is a power of two.

## Timing

- Write latency: 1 edge. Data is visible on a non-bypassed read in the cycle after the write edge.
- Bypassed read: 0 cycles, combinational path wr_data -> rd_data.
- Read latency from address change: combinational, no clock.
- wr_ack rises one edge after the accepted write and falls the following edge unless another write is accepted. It stays high across back-to-back writes.
- Reset values:
  - every word = RESET_VAL
  - wr_ack = 0
  - rd_data_x reflects RESET_VAL (or 0 for the zero register)
- Reset mid-write: rst asserted in the same cycle as wr_en. The write is lost and the word holds RESET_VAL after rst deasserts.
- Deassertion of rst is synchronous to the design. The first write is accepted at the first edge with rst=0.

## Test plan

- Reset: W=32, RESET_VAL=32'hDEAD_BEEF, ZERO_REG=1, pulse rst mid-cycle.
  - Required: rd_data_a at addr 5 = DEADBEEF.
  - Required: rd_data_b at addr 0 = 0.
  - Required: wr_ack=0 immediately, before any clk edge.
- Write/readback: write 32'h1234_5678 to addr 7, then 32'hA5A5_A5A5 to addr 31.
  - Required: next cycle, A@7 = 12345678 and B@31 = A5A5A5A5.
  - Required: wr_ack high for two consecutive cycles.
- Bypass vs no-bypass: addr 3 holds 32'h1. Write 32'h2 to addr 3 with rd_addr_a=3.
  - Required, BYPASS=1: rd_data_a = 2 before the edge.
  - Required, BYPASS=0: rd_data_a = 1 before the edge and 2 after it.
- Zero register: write 32'hFFFF_FFFF to addr 0 with A reading addr 0.
  - Required, ZERO_REG=1: rd_data_a stays 0 before and after the edge, and wr_ack=1.
  - Required, ZERO_REG=0: rd_data_a = FFFFFFFF after the edge.
- clr priority: fill addrs 1..4 with 1..4, then assert clr and wr_en (addr 2, 32'h99) in the same cycle.
  - Required: all words = RESET_VAL and wr_ack=0 next cycle.
- Reset mid-write and width sweep: assert rst during a wr_en cycle to addr 9.
  - Required: addr 9 = RESET_VAL after rst deasserts.
  - Repeat write/readback with W=8, AW=2 (DEPTH=4) and W=64, AW=6, checking all addresses including DEPTH-1.
